// File: rtl/led_panel_pkg.sv
// Shared constants for the front-panel lamp driver: default geometry, counter
// width helper and the channel numbering of the named relay-computer signals.
package led_panel_pkg;

  localparam int DEF_N_CH        = 64;
  localparam int DEF_COLS        = 8;
  localparam int DEF_STRETCH_CYC = 4;
  localparam int DEF_ROW_DWELL   = 16;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int count_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Instruction register bits, row 0.
  localparam int CH_INST0 = 0;
  localparam int CH_INST1 = 1;
  localparam int CH_INST2 = 2;
  localparam int CH_INST3 = 3;
  localparam int CH_INST4 = 4;
  localparam int CH_INST5 = 5;
  localparam int CH_INST6 = 6;
  localparam int CH_INST7 = 7;

  // Clock pulses pA..pT; there is no pP on the machine, so pQ follows pO.
  localparam int CH_PA = 8;
  localparam int CH_PB = 9;
  localparam int CH_PC = 10;
  localparam int CH_PD = 11;
  localparam int CH_PE = 12;
  localparam int CH_PF = 13;
  localparam int CH_PG = 14;
  localparam int CH_PH = 15;
  localparam int CH_PI = 16;
  localparam int CH_PJ = 17;
  localparam int CH_PK = 18;
  localparam int CH_PL = 19;
  localparam int CH_PM = 20;
  localparam int CH_PN = 21;
  localparam int CH_PO = 22;
  localparam int CH_PQ = 23;
  localparam int CH_PR = 24;
  localparam int CH_PS = 25;
  localparam int CH_PT = 26;

  // Register load / select strobes and ALU function lines.
  localparam int CH_LD_A  = 32;
  localparam int CH_LD_B  = 33;
  localparam int CH_LD_C  = 34;
  localparam int CH_LD_D  = 35;
  localparam int CH_SEL_A = 40;
  localparam int CH_SEL_B = 41;
  localparam int CH_SEL_C = 42;
  localparam int CH_SEL_D = 43;
  localparam int CH_F1    = 48;
  localparam int CH_F2    = 49;
  localparam int CH_F3    = 50;

endpackage

// File: rtl/led_stretcher.sv
// One lamp channel: stretches any sampled-high input to at least STRETCH_CYC
// clocks of on-time so single-clock pulses remain visible on the panel.
module led_stretcher
  import led_panel_pkg::*;
#(
  parameter int STRETCH_CYC = DEF_STRETCH_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lit
);

  localparam int CW = count_width(STRETCH_CYC);

  logic [CW-1:0] cnt;

  // A high input always reloads, so a retrigger mid-count leaves no gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (din) begin
      cnt <= CW'(STRETCH_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign lit = (cnt != '0);

endmodule

// File: rtl/led_panel_driver.sv
// Front-panel lamp driver: per-channel pulse stretchers, a freezable snapshot
// and a row-scanned LED matrix with a blank clock at the start of every row.
module led_panel_driver
  import led_panel_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int COLS        = DEF_COLS,
  parameter int STRETCH_CYC = DEF_STRETCH_CYC,
  parameter int ROW_DWELL   = DEF_ROW_DWELL,
  localparam int ROWS       = N_CH / COLS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] ch_in,
  input  logic            freeze,
  input  logic            lamp_test,
  output logic [ROWS-1:0] row_en,
  output logic [COLS-1:0] col_drv,
  output logic            frame_start
);

  localparam int DW = count_width(ROW_DWELL - 1);
  localparam int RW = count_width(ROWS - 1);

  logic [N_CH-1:0]            lit;
  logic [N_CH-1:0]            snap;
  logic [ROWS-1:0][COLS-1:0]  snap_rows;
  logic [DW-1:0]              dwell_q;
  logic [RW-1:0]              row_q;
  logic                       dwell_last;
  logic                       row_last;
  logic                       blank;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_stretcher #(
      .STRETCH_CYC(STRETCH_CYC)
    ) u_stretch (
      .clk  (clk),
      .reset(reset),
      .din  (ch_in[i]),
      .lit  (lit[i])
    );
  end

  // The stretchers keep running while frozen; only the displayed copy holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap <= '0;
    end else if (!freeze) begin
      snap <= lit;
    end
  end

  // Channel i lands on row i/COLS, column i%COLS.
  assign snap_rows  = snap;
  assign dwell_last = (dwell_q == DW'(ROW_DWELL - 1));
  assign row_last   = (row_q == RW'(ROWS - 1));
  assign blank      = (dwell_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q <= '0;
      row_q   <= '0;
    end else if (dwell_last) begin
      dwell_q <= '0;
      row_q   <= row_last ? '0 : row_q + RW'(1);
    end else begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  // Outputs are registered from the pre-edge scan position, so dwell 0 of
  // every row is an all-off clock between consecutive row selects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_en      <= '0;
      col_drv     <= '0;
      frame_start <= 1'b0;
    end else begin
      row_en      <= blank ? '0 : (ROWS'(1) << row_q);
      col_drv     <= blank ? '0 : (lamp_test ? '1 : snap_rows[row_q]);
      frame_start <= blank && (row_q == '0);
    end
  end

endmodule

// File: doc/led_panel_driver.md
# led_panel_driver

Parametrised front-panel lamp driver for the relay computer model. It takes N_CH raw status bits (instruction bits, clock pulses pA–pT, load/select/function controls) and stretches each short pulse to a visible minimum on-time. It can freeze a snapshot of the lamp state, and drives a row-scanned, multiplexed LED matrix with blanking and lamp-test. It sits between the control/sequencer outputs and the physical panel, replacing the flat per-signal lamp bus.

## Interface
- N_CH, 64: number of status channels. Must be a multiple of COLS.
- COLS, 8: LEDs per matrix row.
- ROWS, N_CH/COLS: derived, not overridable.
- STRETCH_CYC, 4: minimum on-time in clocks for any sampled-high channel. Must be at least 1.
- ROW_DWELL, 16: clocks per row, including 1 blank clock. Must be at least 2.
- clk, input, 1: single clock. All state is on the rising edge.
- reset, input, 1: asynchronous, active-high.
- ch_in, input, N_CH: raw status bits, sampled every edge.
- freeze, input, 1: while 1, the displayed snapshot holds.
- lamp_test, input, 1: while 1, all columns are driven on during active row time.
- row_en, output, ROWS: one-hot row select, active-high. All zero when blanking.
- col_drv, output, COLS: column drive for the selected row, active-high.
- frame_start, output, 1: one-clock pulse at the start of row 0.

## Operation
- **Stretcher, per channel i.** Counter cnt[i] has width $clog2(STRETCH_CYC+1).
  - If ch_in[i]=1, load cnt[i] with STRETCH_CYC.
  - Otherwise decrement cnt[i], saturating at 0.
  - lit[i] = (cnt[i] != 0).
  - Retrigger while counting reloads the counter, so there is no gap.
- **Snapshot.**
  - snap <= lit when freeze=0.
  - snap holds when freeze=1.
  - The stretchers keep running while frozen.
- **Scan counters.**
  - dwell_q runs 0..ROW_DWELL-1. row_q runs 0..ROWS-1.
  - row_q increments when dwell_q wraps, and wraps from ROWS-1 to 0.
- **Output registers.** They are updated every edge from the pre-edge (row_q, dwell_q):
  - row_en <= (dwell_q==0) ? 0 : onehot(row_q).
  - col_drv <= (dwell_q==0) ? 0 : (lamp_test ? all-ones : snap[row_q*COLS +: COLS]).
  - frame_start <= (row_q==0 && dwell_q==0).
  - Channel i maps to row i/COLS, column i%COLS.
- **Reset.** Asserting reset at any time, including mid-row or mid-stretch, asynchronously clears the following to 0 on the same cycle:
  - cnt, snap, row_q, dwell_q;
  - row_en, col_drv, frame_start.
- **Mode changes.**
  - freeze and lamp_test take effect on the next edge; there is no scan restart.
  - lamp_test does not alter snap.

## Timing
- Latency from ch_in to col_drv: ch_in is high before edge e.
  - lit=1 after e.
  - snap=1 after e+1.
  - col_drv reflects it after e+2, if that channel's row is active at e+2.
- **Single-cycle pulse sampled at edge e.** lit is high for exactly STRETCH_CYC clocks, after edges e..e+STRETCH_CYC-1.
- **Held input.** lit stays high while ch_in=1, then for STRETCH_CYC clocks after the last sampled-high edge.
- **Scan.**
  - Frame period is ROWS×ROW_DWELL clocks.
  - Each row is blank for 1 clock, then active for ROW_DWELL-1 clocks.
  - Exactly one row_en bit is set during active time.
- **First edge after reset release.** Outputs show position (row 0, dwell 0): row_en=0, col_drv=0, frame_start=1.
- **frame_start** recurs every ROWS×ROW_DWELL clocks.
- **Blanking.** The blank clock guarantees row_en is all zero between any two consecutive one-hot values.

## Structure
- Package led_panel_pkg holds:
  - default parameter constants;
  - a width-helper function for the cnt, dwell and row counter widths;
  - the channel index constants for the named panel signals (inst0–7, pA–pT excluding P, ld_*/sel_*/f1–f3).
- Sub-module led_stretcher holds one channel's counter and lit bit. It is instantiated N_CH times via generate.
- The scan counters, snapshot register and output decode live in the top module.

## Test plan
1. **Reset.** Assert reset mid-row with lamps lit → row_en, col_drv and frame_start are 0 immediately and stay 0 until release. After release, frame_start=1 on the first edge.
2. **Scan order.** Defaults, with ch_in=0 and lamp_test=1 → frame_start every 128 clocks. Each row shows 1 blank clock then 15 clocks with row_en=1<<r and col_drv=8'hFF. r steps 0→7, then wraps.
3. **Stretch.** A 1-clock pulse on ch_in[10] → lit[10] high for exactly 4 clocks. col_drv[2] is 1 during row 1 active time over the matching window, 2 clocks delayed.
4. **Retrigger.** Pulses on ch 0 at edges t and t+3 → lit[0] is continuously high from after t through after t+6 (7 clocks), with no dropout.
5. **Freeze.** Set ch_in[63]=1, then assert freeze and clear ch_in → col_drv[7] stays 1 in every row 7 active period for over 1000 clocks. Release freeze → it goes to 0 within 2 clocks, once the stretch has expired.
6. **Lamp test overrides and restores.** snap=0 with lamp_test toggled → col_drv is all-ones only in active clocks and 0 in blank clocks. Dropping lamp_test restores the snap data on the next edge.
